// File: rtl/rc4_stream_xor.sv
// Purpose: XORs a byte stream with RC4 keystream bytes buffered in an 8-entry FIFO.
// Latency: 1 cycle from an accepted din byte to dout_valid.
// Backpressure: a stalled dout holds din_ready low; a full FIFO drops keystream and sets ovf_err.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start, msg_len     message start request and byte length (sampled on accepted start)
//   init_done          keystream generator key schedule complete
//   ks_start           keystream generator start/valid request (high while waiting for init)
//   ks_valid, ks_byte  keystream byte from the generator
//   din*, dout*        data in / XOR result out, valid/ready handshakes
//   busy, done         message in progress; one-cycle completion pulse
//   ovf_err, byte_cnt  sticky keystream overflow flag; bytes delivered this message
//
// Build option: define RC4_DROP_EN to discard the first 256 keystream bytes after
// reset (RC4-drop[256]). Without it the DROP state is never entered.

module rc4_stream_xor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] msg_len,
  input  logic        init_done,
  output logic        ks_start,
  input  logic        ks_valid,
  input  logic [7:0]  ks_byte,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        ovf_err,
  output logic [15:0] byte_cnt
);

`ifdef RC4_DROP_EN
  localparam logic DROP_ON = 1'b1;
`else
  localparam logic DROP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_INIT = 2'd1,
    DROP      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] len_q;      // latched message length
  logic [15:0] acc_cnt;    // bytes accepted on din this message
  logic [8:0]  drop_cnt;   // keystream bytes discarded in DROP
  logic        drop_pend;  // drop still owed since reset

  // Keystream FIFO
  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  fifo_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;

  // Handshake / control decode
  logic        start_go;
  logic        accept;
  logic        out_hs;
  logic        last_out;
  logic        flush;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        ovf_set;

  assign fifo_full  = (fifo_cnt == 4'd8);
  assign fifo_empty = (fifo_cnt == 4'd0);
  assign fifo_head  = fifo_mem[rd_ptr];

  // din_ready looks at dout_ready directly so a draining output slot can be
  // refilled in the same cycle, giving one byte per cycle throughput.
  assign din_ready = (state == RUN) && !fifo_empty &&
                     (!dout_valid || dout_ready) && (acc_cnt < len_q);

  assign start_go = (state == IDLE) && start && (msg_len != 16'd0);
  assign accept   = din_valid && din_ready;
  assign out_hs   = dout_valid && dout_ready;
  assign last_out = out_hs && (state == RUN) && ((byte_cnt + 16'd1) == len_q);
  assign flush    = start_go || last_out;

  // Keystream is only buffered while RUN; earlier bytes belong to nobody.
  assign push_req = (state == RUN) && ks_valid;
  assign pop      = accept;
  // On a full FIFO a simultaneous pop frees the slot, so the push is kept.
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;

  // FIFO storage: no reset needed, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ks_byte;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      fifo_cnt <= 4'd0;
    end else if (flush) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      fifo_cnt <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= 16'd0;
      acc_cnt    <= 16'd0;
      byte_cnt   <= 16'd0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      ks_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf_err    <= 1'b0;
      drop_cnt   <= 9'd0;
      drop_pend  <= 1'b1;
    end else begin
      done <= 1'b0;

      if (start_go) begin
        ovf_err <= 1'b0;
      end else if (ovf_set) begin
        ovf_err <= 1'b1;
      end

      // Output register: load on accept, otherwise release once taken.
      if (accept) begin
        dout       <= din ^ fifo_head;
        dout_valid <= 1'b1;
        acc_cnt    <= acc_cnt + 16'd1;
      end else if (out_hs) begin
        dout_valid <= 1'b0;
      end

      if (out_hs) begin
        byte_cnt <= byte_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (msg_len != 16'd0) begin
              len_q    <= msg_len;
              acc_cnt  <= 16'd0;
              byte_cnt <= 16'd0;
              state    <= WAIT_INIT;
              ks_start <= 1'b1;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        WAIT_INIT: begin
          // A generator that is already initialised passes straight through.
          if (init_done) begin
            ks_start <= 1'b0;
            if (DROP_ON && drop_pend) begin
              state <= DROP;
            end else begin
              state <= RUN;
            end
          end
        end

        DROP: begin
          if (ks_valid) begin
            if (drop_cnt == 9'd255) begin
              drop_cnt  <= 9'd0;
              drop_pend <= 1'b0;
              state     <= RUN;
            end else begin
              drop_cnt <= drop_cnt + 9'd1;
            end
          end
        end

        RUN: begin
          if (last_out) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          ks_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_xor.sv
module tb_rc4_stream_xor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] msg_len;
  logic        init_done;
  logic        ks_start;
  logic        ks_valid;
  logic [7:0]  ks_byte;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;
  logic        ovf_err;
  logic [15:0] byte_cnt;

  rc4_stream_xor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg_len    (msg_len),
    .init_done  (init_done),
    .ks_start   (ks_start),
    .ks_valid   (ks_valid),
    .ks_byte    (ks_byte),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .ovf_err    (ovf_err),
    .byte_cnt   (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one comparison per output handshake.
  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dout_unexpected: got 0x%0h, expected no output", dout);
      end else begin
        chk("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [15:0] len);
    msg_len = len;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic ks_put(input logic [7:0] b);
    ks_valid = 1'b1;
    ks_byte  = b;
    tick(1);
    ks_valid = 1'b0;
  endtask

  task automatic send_din(input logic [7:0] b, input logic [7:0] e);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(e);
    din       = b;
    din_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("din_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dout"},       {24'd0, dout},  32'd0);
    chk({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
    chk({tag, "_din_ready"},  {31'd0, din_ready},  32'd0);
    chk({tag, "_ks_start"},   {31'd0, ks_start},   32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_done"},       {31'd0, done},       32'd0);
    chk({tag, "_ovf_err"},    {31'd0, ovf_err},    32'd0);
    chk({tag, "_byte_cnt"},   {16'd0, byte_cnt},   32'd0);
  endtask

  int d0;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    msg_len    = 16'd0;
    init_done  = 1'b0;
    ks_valid   = 1'b0;
    ks_byte    = 8'd0;
    din        = 8'd0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b1;
    tick(2);

    // Keystream drop behaviour, first message after reset
    init_done = 1'b1;
    d0 = done_cnt;
    start_msg(16'd2);
    tick(1);
    for (int i = 0; i < 256; i++) ks_put(8'(i));
    ks_put(8'h5A);
    ks_put(8'hA5);
`ifdef RC4_DROP_EN
    send_din(8'h00, 8'h5A);
    send_din(8'h00, 8'hA5);
`else
    send_din(8'h00, 8'h00);
    send_din(8'h00, 8'h01);
`endif
    wait_done();
    chk("drop_byte_cnt", {16'd0, byte_cnt}, 32'd2);
    chk("drop_done_cnt", done_cnt - d0, 32'd1);

    // Basic 4-byte message with late init_done
    init_done = 1'b0;
    d0 = done_cnt;
    start_msg(16'd4);
    chk("t27_busy", {31'd0, busy}, 32'd1);
    chk("t27_ovf_cleared", {31'd0, ovf_err}, 32'd0);
    chk("t27_ks_start_wait", {31'd0, ks_start}, 32'd1);
    tick(9);
    chk("t27_ks_start_hold", {31'd0, ks_start}, 32'd1);
    init_done = 1'b1;
    tick(1);
    chk("t27_ks_start_run", {31'd0, ks_start}, 32'd0);
    ks_put(8'h11);
    ks_put(8'h22);
    ks_put(8'h33);
    ks_put(8'h44);
    send_din(8'hAA, 8'hBB);
    send_din(8'hBB, 8'h99);
    send_din(8'hCC, 8'hFF);
    send_din(8'hDD, 8'h99);
    wait_done();
    tick(2);
    chk("t27_byte_cnt", {16'd0, byte_cnt}, 32'd4);
    chk("t27_done_cnt", done_cnt - d0, 32'd1);
    chk("t27_busy_after", {31'd0, busy}, 32'd0);

    // Output stall for 5 cycles; init_done already high
    d0 = done_cnt;
    start_msg(16'd3);
    chk("t28_ks_start", {31'd0, ks_start}, 32'd1);
    tick(1);
    chk("t28_fast_run", {31'd0, ks_start}, 32'd0);
    ks_put(8'h01);
    ks_put(8'h02);
    ks_put(8'h03);
    dout_ready = 1'b0;
    send_din(8'h10, 8'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t28_dout_stable", {24'd0, dout}, 32'h11);
      chk("t28_din_ready_low", {31'd0, din_ready}, 32'd0);
    end
    tick(1);
    dout_ready = 1'b1;
    send_din(8'h20, 8'h22);
    send_din(8'h30, 8'h33);
    wait_done();
    chk("t28_byte_cnt", {16'd0, byte_cnt}, 32'd3);
    chk("t28_done_cnt", done_cnt - d0, 32'd1);

    // Overflow: 9 keystream bytes with no consumer
    start_msg(16'd8);
    tick(1);
    for (int i = 1; i <= 8; i++) ks_put(8'(i));
    chk("t29_ovf_before", {31'd0, ovf_err}, 32'd0);
    ks_put(8'h09);
    chk("t29_ovf_after", {31'd0, ovf_err}, 32'd1);
    for (int i = 1; i <= 8; i++) send_din(8'h00, 8'(i));
    wait_done();
    chk("t29_ovf_sticky", {31'd0, ovf_err}, 32'd1);
    chk("t29_byte_cnt", {16'd0, byte_cnt}, 32'd8);

    // Zero-length message
    d0 = done_cnt;
    start_msg(16'd0);
    chk("t30_done", {31'd0, done}, 32'd1);
    chk("t30_busy", {31'd0, busy}, 32'd0);
    chk("t30_ks_start", {31'd0, ks_start}, 32'd0);
    tick(1);
    chk("t30_done_off", {31'd0, done}, 32'd0);
    chk("t30_busy2", {31'd0, busy}, 32'd0);
    chk("t30_ks_start2", {31'd0, ks_start}, 32'd0);
    chk("t30_done_cnt", done_cnt - d0, 32'd1);

    // Reset mid-message, then a clean 2-byte message
    d0 = done_cnt;
    start_msg(16'd6);
    chk("t31_ovf_cleared", {31'd0, ovf_err}, 32'd0);
    tick(1);
    for (int i = 0; i < 6; i++) ks_put(8'(8'h10 + i));
    send_din(8'h01, 8'h11);
    send_din(8'h02, 8'h13);
    tick(1);
    rst = 1'b0;
    #1;
    check_reset_vals("t31_rst");
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("t31_no_done", done_cnt - d0, 32'd0);
    chk("t31_queue_empty", exp_q.size(), 32'd0);
    start_msg(16'd2);
    tick(1);
    ks_put(8'hA0);
    ks_put(8'h0B);
    send_din(8'h0F, 8'hAF);
    send_din(8'hF0, 8'hFB);
    wait_done();
    chk("t31_byte_cnt", {16'd0, byte_cnt}, 32'd2);
    chk("t31_busy_after", {31'd0, busy}, 32'd0);
    chk("t31_done_cnt", done_cnt - d0, 32'd1);

    tick(2);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
